// File: rtl/spi_bus_arbiter_if.sv
// Shared SPI connection bundle: both HPS-side master ports plus the physical bus.
// Latency: none; the bundle is wires only.
// Backpressure: none; SPI has no flow control, and the arbiter suppresses traffic instead.
//
// Signals (slave = arbiter view):
//   adc_sclk/adc_mosi/adc_ss_n  in   ADC master outputs
//   adc_miso                    out  MISO returned to ADC master
//   can_sclk/can_mosi/can_ss_n  in   CAN master outputs
//   can_miso                    out  MISO returned to CAN master
//   bus_sclk/bus_mosi/bus_ss_n  out  physical bus, bus_ss_n = {can_ss_n, adc_ss_n}
//   bus_miso                    in   physical MISO
interface spi_bus_arbiter_if #(
  parameter int NUM_ADC_SS = 2,
  parameter int NUM_CAN_SS = 3
);
  logic                               adc_sclk;
  logic                               adc_mosi;
  logic [NUM_ADC_SS-1:0]              adc_ss_n;
  logic                               adc_miso;
  logic                               can_sclk;
  logic                               can_mosi;
  logic [NUM_CAN_SS-1:0]              can_ss_n;
  logic                               can_miso;
  logic                               bus_sclk;
  logic                               bus_mosi;
  logic [NUM_ADC_SS+NUM_CAN_SS-1:0]   bus_ss_n;
  logic                               bus_miso;

  modport slave (
    input  adc_sclk, adc_mosi, adc_ss_n,
    input  can_sclk, can_mosi, can_ss_n,
    input  bus_miso,
    output adc_miso, can_miso,
    output bus_sclk, bus_mosi, bus_ss_n
  );

  modport master (
    output adc_sclk, adc_mosi, adc_ss_n,
    output can_sclk, can_mosi, can_ss_n,
    output bus_miso,
    input  adc_miso, can_miso,
    input  bus_sclk, bus_mosi, bus_ss_n
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Sequential owner arbiter for the shared GPIO_0 SPI bus (ADC vs CAN master).
// Latency: master->bus 1 clk (registered sclk/mosi/ss_n together); bus_miso->master 0 clk.
// Backpressure: none; a non-granted master is silently suppressed and its attempts are counted.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   sel_adc         requested owner (1=ADC, 0=CAN)
//   io              spi_bus_arbiter_if.slave bundle (master ports + physical bus)
//   grant_adc       current owner (1=ADC)
//   switching       high while an ownership change is in progress (DRAIN or GAP)
//   conflict        one-cycle pulse per conflict event
//   conflict_cnt    saturating 8-bit conflict count
//
// Build option: define SPI_ARB_CONFLICT_CNT_EN to build conflict detection and the
// counter; without it conflict and conflict_cnt read 0 (suppression is unaffected).
module spi_bus_arbiter #(
  parameter int NUM_ADC_SS = 2,
  parameter int NUM_CAN_SS = 3,
  parameter int SWITCH_GAP = 4,
  parameter bit CPOL       = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel_adc,
  spi_bus_arbiter_if.slave    io,
  output logic                grant_adc,
  output logic                switching,
  output logic                conflict,
  output logic [7:0]          conflict_cnt
);

  localparam int SSW = NUM_ADC_SS + NUM_CAN_SS;
  localparam int CW  = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(SWITCH_GAP - 1);

  localparam logic [1:0] ST_OWN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           r_grant_adc;
  logic           w_grant_nxt;

  logic           r_bus_sclk;
  logic           r_bus_mosi;
  logic [SSW-1:0] r_bus_ss_n;
  logic           w_bus_sclk_nxt;
  logic           w_bus_mosi_nxt;
  logic [SSW-1:0] w_bus_ss_n_nxt;

  logic           w_adc_act;
  logic           w_can_act;
  logic           w_owner_act;
  logic           w_idle;

  assign w_adc_act   = ~&io.adc_ss_n;
  assign w_can_act   = ~&io.can_ss_n;
  assign w_owner_act = r_grant_adc ? w_adc_act : w_can_act;

  // Owner FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant_adc;
    case (r_state)
      ST_OWN: begin
        if (sel_adc != r_grant_adc) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A request withdrawn before the owner goes idle cancels the switch.
        if (sel_adc == r_grant_adc) begin
          w_state_nxt = ST_OWN;
        end else if (!w_owner_act) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        // sel_adc is sampled only at gap exit; the full gap is always observed.
        if (r_cnt == '0) begin
          w_grant_nxt = sel_adc;
          w_state_nxt = ST_OWN;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_cnt_nxt   = GAP_LOAD;
      end
    endcase
  end

  // Bus is forced idle while in GAP and already on the edge that enters GAP,
  // so sclk/mosi park cleanly in the same cycle ss_n reaches all ones.
  assign w_idle = (r_state == ST_GAP) || (w_state_nxt == ST_GAP);

  always_comb begin
    w_bus_sclk_nxt = CPOL;
    w_bus_mosi_nxt = 1'b0;
    w_bus_ss_n_nxt = '1;
    if (!w_idle) begin
      if (r_grant_adc) begin
        w_bus_sclk_nxt                   = io.adc_sclk;
        w_bus_mosi_nxt                   = io.adc_mosi;
        w_bus_ss_n_nxt[NUM_ADC_SS-1:0]   = io.adc_ss_n;
      end else begin
        w_bus_sclk_nxt                   = io.can_sclk;
        w_bus_mosi_nxt                   = io.can_mosi;
        w_bus_ss_n_nxt[SSW-1:NUM_ADC_SS] = io.can_ss_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_GAP;
      r_cnt       <= GAP_LOAD;
      r_grant_adc <= 1'b0;
      r_bus_sclk  <= CPOL;
      r_bus_mosi  <= 1'b0;
      r_bus_ss_n  <= '1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_grant_adc <= w_grant_nxt;
      r_bus_sclk  <= w_bus_sclk_nxt;
      r_bus_mosi  <= w_bus_mosi_nxt;
      r_bus_ss_n  <= w_bus_ss_n_nxt;
    end
  end

  assign io.bus_sclk = r_bus_sclk;
  assign io.bus_mosi = r_bus_mosi;
  assign io.bus_ss_n = r_bus_ss_n;

  // MISO return path is combinational on the registered grant; idle-high otherwise.
  assign io.adc_miso = ((r_state != ST_GAP) &&  r_grant_adc) ? io.bus_miso : 1'b1;
  assign io.can_miso = ((r_state != ST_GAP) && !r_grant_adc) ? io.bus_miso : 1'b1;

  assign grant_adc = r_grant_adc;
  assign switching = (r_state != ST_OWN);

`ifdef SPI_ARB_CONFLICT_CNT_EN
  logic       w_foreign_act;
  logic       w_conflict_evt;
  logic       r_foreign_q;
  logic       r_conflict;
  logic [7:0] r_conflict_cnt;

  // Any master counts as foreign while the bus is held idle.
  assign w_foreign_act  = (r_state == ST_GAP) ? (w_adc_act | w_can_act)
                                              : (r_grant_adc ? w_can_act : w_adc_act);
  assign w_conflict_evt = w_foreign_act & ~r_foreign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_foreign_q    <= 1'b0;
      r_conflict     <= 1'b0;
      r_conflict_cnt <= 8'd0;
    end else begin
      r_foreign_q <= w_foreign_act;
      r_conflict  <= w_conflict_evt;
      if (w_conflict_evt && (r_conflict_cnt != 8'hFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end
    end
  end

  assign conflict     = r_conflict;
  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict     = 1'b0;
  assign conflict_cnt = 8'd0;
`endif

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Sits between the two HPS-side Avalon SPI masters (ADC and CAN) and the single shared physical SPI bus on GPIO_0. Replaces the combinational select mux with a sequential arbiter. A change of the software select bit takes effect only after the current owner finishes its transaction and a programmable idle gap has elapsed. A foreign master is never allowed onto the pins mid-frame, and attempts by the non-granted master are counted.

## Interface
Parameters:
- NUM_ADC_SS, 2, ADC master chip-select width
- NUM_CAN_SS, 3, CAN master chip-select width
- SWITCH_GAP, 4, idle cycles (≥1) driven between ownership changes
- CPOL, 0, idle level of bus_sclk

Ports:
- clk  in  1  system clock (same domain as the SPI masters and select PIO)
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- sel_adc  in  1  requested owner, 1=ADC, 0=CAN (SPI select PIO bit 0)
- adc_sclk, adc_mosi  in  1  ADC master outputs
- adc_ss_n  in  NUM_ADC_SS  ADC master selects
- adc_miso  out  1  MISO to ADC master
- can_sclk, can_mosi  in  1  CAN master outputs
- can_ss_n  in  NUM_CAN_SS  CAN master selects
- can_miso  out  1  MISO to CAN master
- bus_sclk, bus_mosi  out  1  physical bus
- bus_ss_n  out  NUM_ADC_SS+NUM_CAN_SS  physical selects, {can_ss_n, adc_ss_n} order
- bus_miso  in  1  physical MISO
- grant_adc  out  1  current owner, 1=ADC
- switching  out  1  high in DRAIN or GAP
- conflict  out  1  one-cycle pulse per conflict event
- conflict_cnt  out  8  saturating conflict count

## Operation
- The owner is active when any bit of its ss_n is low.
- States:
  - OWN: registered bus outputs follow the granted master.
  - DRAIN: a change is pending; the granted master is still passed through.
  - GAP: bus idle (bus_sclk=CPOL, bus_mosi=0, all bus_ss_n=1); a down-counter runs.
- Transitions:
  - OWN→DRAIN when sel_adc≠grant_adc.
  - DRAIN→GAP on the first cycle the owner is inactive. If the owner is inactive already, the transition is made the cycle after entering DRAIN.
  - DRAIN→OWN, with no grant change, if sel_adc returns to grant_adc while in DRAIN.
  - GAP loads SWITCH_GAP-1 and counts to 0. At 0: grant_adc←sel_adc, →OWN.
- If sel_adc toggles during GAP, the value sampled at GAP exit wins. If that value equals the old grant, the gap is still fully observed.
- Outputs by state:
  - bus_ss_n bits belonging to the non-granted master are always 1.
  - The granted master's bits pass only in OWN/DRAIN.
  - All bits are 1 in GAP.
- MISO routing:
  - bus_miso goes combinationally to the granted master's miso.
  - The non-granted master's miso is held at 1.
  - During GAP both miso outputs are 1.
- Conflict:
  - A conflict event is the rising edge of "non-granted master active", or of any master active during GAP.
  - Each event pulses conflict for 1 cycle and increments conflict_cnt, saturating at 255.
  - Suppressed traffic is never forwarded.
- Reset values:
  - state=GAP, counter=SWITCH_GAP-1, grant_adc=0.
  - bus_sclk=CPOL, bus_mosi=0, bus_ss_n=all 1s.
  - switching=1, conflict=0, conflict_cnt=0.
- Reset asserted mid-frame forces the idle bus immediately (asynchronously).

## Timing
- Master→bus path: exactly 1 clk latency (registered), and identical for sclk/mosi/ss_n so that edge alignment is preserved.
- bus_miso→master miso: 0 latency, combinational mux on the registered grant.
- Switch latency when the owner is idle:
  - sel_adc changes at cycle N.
  - DRAIN at N+1, GAP at N+2.
  - grant_adc changes, with OWN, at N+2+SWITCH_GAP.
  - First new-owner pin activity appears 1 cycle later.
- Owner busy: GAP entry is delayed until the owner's last ss_n deassertion has been seen. Pins reach all-1s in that same registered cycle.
- conflict is registered and appears 1 cycle after the offending ss_n edge.

## Configuration
- SPI_ARB_CONFLICT_CNT_EN defined: conflict detection, the conflict pulse and the 8-bit saturating counter are built.
- SPI_ARB_CONFLICT_CNT_EN undefined: conflict and conflict_cnt are tied to 0. Suppression of non-granted traffic is unchanged.

## Test plan
- Reset release, sel_adc=0, SWITCH_GAP=4 -> bus idle for 4 cycles, then grant_adc=0 and CAN traffic appears on the pins 1 cycle delayed.
- CAN mid-frame (can_ss_n=3'b110), sel_adc 0→1 -> frame completes intact; 4 idle cycles after can_ss_n=3'b111; then grant_adc=1 and ADC frames pass.
- ADC drives adc_ss_n=2'b10 while grant_adc=0 -> bus_ss_n[1:0] stays 2'b11, conflict pulses once, conflict_cnt 0→1, adc_miso=1.
- 300 conflict events -> conflict_cnt saturates at 255 and stays; with the macro undefined it reads 0.
- sel_adc pulses 0→1→0 within DRAIN -> returns to OWN, grant_adc stays 0, no GAP entered.
- rst asserted during an ADC frame -> bus_ss_n=all 1s and bus_sclk=CPOL asynchronously; after release, the GAP sequence restarts with grant_adc=0.
